hw_mutex_ctrl: RTL and testbench
================================

HW_MUTEX_CTRL -- requirements
Module: hw_mutex_ctrl

Interface
REQ-001 SHALL have parameter NB_CORES, default 4: number of requesting cores.
REQ-002 SHALL have parameter NB_MUTEX, default 2: number of independent mutexes managed.
REQ-003 SHALL have parameter MUTEX_MSG_W, default 32: width of the handoff message.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port core_req_i  input  NB_CORES  per-core request valid, held until granted.
REQ-007 SHALL have port core_op_i  input  NB_CORES  per-core op: 1 = lock, 0 = unlock.
REQ-008 SHALL have port core_mutex_id_i  input  NB_CORES x max(1,$clog2(NB_MUTEX))  target mutex index.
REQ-009 SHALL have port core_wdata_i  input  NB_CORES x MUTEX_MSG_W  message written on unlock.
REQ-010 SHALL have port core_gnt_o  output  NB_CORES  one-hot request accept, combinational.
REQ-011 SHALL have port mutex_event_o  output  NB_CORES  one-cycle pulse: mutex assigned to core.
REQ-012 SHALL have port core_msg_o  output  NB_CORES x MUTEX_MSG_W  message delivered with assignment.
REQ-013 SHALL have port err_o  output  NB_CORES  one-cycle pulse: illegal request by core.

Function
REQ-014 SHALL accept at most one request per cycle; core_gnt_o at most one-hot, asserted only where core_req_i set.
REQ-015 SHALL select among requesting cores round-robin; pointer 0 after reset, moves to granted index+1 (mod NB_CORES).
REQ-016 Requester SHALL hold op, id, wdata stable while core_req_i high and not granted.
REQ-017 SHALL keep per mutex: state {UNLOCKED, LOCKED}, owner index, waiter mask, message register, waiter rr pointer.
REQ-018 Accepted op SHALL update state at the grant edge; mutex_event_o, core_msg_o, err_o registered, visible exactly 1 cycle after grant.
REQ-019 Lock on UNLOCKED mutex: state LOCKED, owner = requester, mutex_event_o[requester] pulses, core_msg_o[requester] = mutex message.
REQ-020 Lock on LOCKED mutex by non-owner, non-waiter: requester bit set in waiter mask, no event, no err.
REQ-021 Lock by current owner or existing waiter: err_o[requester] pulses, no state change.
REQ-022 Unlock by owner: message register = requester wdata.
REQ-023 Unlock by owner, waiter mask nonzero: new owner = first waiter scanning from old owner+1 upward with wrap; its bit cleared; its event pulses; core_msg_o = new wdata.
REQ-024 Unlock by owner, waiter mask zero: state UNLOCKED, owner unchanged as don't-care, no event.
REQ-025 Unlock by non-owner or of UNLOCKED mutex: err_o[requester] pulses, no state change, message kept.
REQ-026 core_mutex_id_i >= NB_MUTEX: request granted normally, err_o pulses, no mutex state changes.
REQ-027 mutex_event_o and err_o SHALL never both be high for the same core in one cycle; each at most one-hot per cycle.
REQ-028 core_msg_o[i] SHALL hold its value until the next assignment to core i.

Reset
REQ-029 rst_i high at clock edge SHALL set all mutexes UNLOCKED, waiter masks 0, messages 0, owners 0, all rr pointers 0.
REQ-030 During and after reset: mutex_event_o, err_o = 0, core_msg_o = 0; core_gnt_o = 0 while rst_i high.
REQ-031 Reset mid-operation SHALL drop waiters and pending pulses; no event emitted for any pre-reset request.

Structure
REQ-032 mutex state enum and op encoding (LOCK=1, UNLOCK=0) SHALL be in event_unit_pkg.
REQ-033 One sub-module mutex_rr_pick (vector + start index -> one-hot + binary + none flag), reused for input arbitration and per-mutex waiter selection.

Verification
REQ-034 Core 2 locks mutex 0 from reset -> gnt[2] same cycle; next cycle event[2]=1, msg_o[2]=0.
REQ-035 Cores 0,1,3 lock mutex 1 in one cycle -> gnts 0,1,3 in consecutive cycles; only core 0 events; mask=0b1010.
REQ-036 Continue: core 0 unlocks mutex 1 with 0xCAFE -> event[1], msg_o[1]=0xCAFE; core 1 unlocks with 0xBEEF -> event[3], msg_o[3]=0xBEEF; core 3 unlocks -> UNLOCKED, no event.
REQ-037 Core 1 unlocks mutex 0 owned by core 2 -> err[1] pulse, owner stays 2; core 2 locks mutex 0 again -> err[2]; id=3 with NB_MUTEX=2 -> err.
REQ-038 All 4 cores request continuously -> grants cycle 0,1,2,3,0 with no starvation.
REQ-039 Assert rst_i with 2 waiters queued -> after release all mutexes UNLOCKED, no events; core 3 lock gets event next cycle after grant.

Source files
------------

// File: rtl/event_unit_pkg.sv
// Shared types for the hardware mutex controller.
// Holds the mutex state enum, op encoding and an index-width helper.
package event_unit_pkg;

    typedef enum logic {
        MUTEX_UNLOCKED = 1'b0,
        MUTEX_LOCKED   = 1'b1
    } mutex_state_e;

    localparam logic OP_UNLOCK = 1'b0;
    localparam logic OP_LOCK   = 1'b1;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mutex_rr_pick.sv
// Round-robin pick: first set bit of vec_i scanning up from start_i.
// Ports: vec_i, start_i in; onehot_o, idx_o (binary), none_o out.
module mutex_rr_pick
    import event_unit_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  vec_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          none_o
);

    always_comb begin : pick
        int unsigned p;
        p        = 0;
        onehot_o = '0;
        idx_o    = '0;
        none_o   = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            p = (int'(start_i) + k) % N;
            if (none_o && vec_i[p[IW-1:0]]) begin
                onehot_o[p[IW-1:0]] = 1'b1;
                idx_o               = p[IW-1:0];
                none_o              = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hw_mutex_ctrl.sv
// Hardware mutex controller: one request accepted per cycle, round-robin.
// Ports: clk_i, rst_i, core_req/op/mutex_id/wdata in; gnt, event, msg, err out.
module hw_mutex_ctrl
    import event_unit_pkg::*;
#(
    parameter  int unsigned NB_CORES    = 4,
    parameter  int unsigned NB_MUTEX    = 2,
    parameter  int unsigned MUTEX_MSG_W = 32,
    localparam int unsigned CW          = idx_w(NB_CORES),
    localparam int unsigned MW          = idx_w(NB_MUTEX)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_CORES-1:0]                  core_req_i,
    input  logic [NB_CORES-1:0]                  core_op_i,
    input  logic [NB_CORES-1:0][MW-1:0]          core_mutex_id_i,
    input  logic [NB_CORES-1:0][MUTEX_MSG_W-1:0] core_wdata_i,
    output logic [NB_CORES-1:0]                  core_gnt_o,
    output logic [NB_CORES-1:0]                  mutex_event_o,
    output logic [NB_CORES-1:0][MUTEX_MSG_W-1:0] core_msg_o,
    output logic [NB_CORES-1:0]                  err_o
);

    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] i);
        return CW'((int'(i) + 1) % NB_CORES);
    endfunction

    // Per-mutex state
    mutex_state_e              state_q   [NB_MUTEX];
    logic [CW-1:0]             owner_q   [NB_MUTEX];
    logic [NB_CORES-1:0]       waiters_q [NB_MUTEX];
    logic [CW-1:0]             wptr_q    [NB_MUTEX];
    logic [MUTEX_MSG_W-1:0]    msg_q     [NB_MUTEX];

    logic [NB_CORES-1:0]       w_onehot  [NB_MUTEX];
    logic [CW-1:0]             w_idx     [NB_MUTEX];
    logic                      w_none    [NB_MUTEX];

    logic [CW-1:0]                  rr_ptr_q;
    logic [NB_CORES-1:0]            evt_q;
    logic [NB_CORES-1:0]            err_q;
    logic [NB_CORES-1:0][MUTEX_MSG_W-1:0] msg_out_q;

    // Input arbitration
    logic [NB_CORES-1:0] arb_onehot;
    logic [CW-1:0]       arb_idx;
    logic                arb_none;
    logic                acc;

    mutex_rr_pick #(.N(NB_CORES)) u_arb (
        .vec_i    (core_req_i),
        .start_i  (rr_ptr_q),
        .onehot_o (arb_onehot),
        .idx_o    (arb_idx),
        .none_o   (arb_none)
    );

    assign core_gnt_o = rst_i ? '0 : arb_onehot;
    assign acc        = !rst_i && !arb_none;

    // Waiter selection: scan from the owner's successor
    for (genvar m = 0; m < NB_MUTEX; m++) begin : g_wait
        mutex_rr_pick #(.N(NB_CORES)) u_pick (
            .vec_i    (waiters_q[m]),
            .start_i  (wptr_q[m]),
            .onehot_o (w_onehot[m]),
            .idx_o    (w_idx[m]),
            .none_o   (w_none[m])
        );
    end

    // Granted request fields
    logic                   sel_op;
    logic [MW-1:0]          sel_id;
    logic [MUTEX_MSG_W-1:0] sel_wdata;
    logic                   id_ok;
    logic [MW-1:0]          mid;

    assign sel_op    = core_op_i[arb_idx];
    assign sel_id    = core_mutex_id_i[arb_idx];
    assign sel_wdata = core_wdata_i[arb_idx];
    assign id_ok     = 32'(sel_id) < NB_MUTEX;
    // Out-of-range ids are steered to mutex 0 but never act on it
    assign mid       = id_ok ? sel_id : '0;

    logic is_locked;
    logic is_owner;
    logic is_waiter;

    assign is_locked = (state_q[mid] == MUTEX_LOCKED);
    assign is_owner  = (owner_q[mid] == arb_idx);
    assign is_waiter = waiters_q[mid][arb_idx];

    logic do_bad_id;
    logic do_acquire;
    logic do_enqueue;
    logic do_lock_err;
    logic do_handoff;
    logic do_release;
    logic do_unlock_err;

    always_comb begin
        do_bad_id     = 1'b0;
        do_acquire    = 1'b0;
        do_enqueue    = 1'b0;
        do_lock_err   = 1'b0;
        do_handoff    = 1'b0;
        do_release    = 1'b0;
        do_unlock_err = 1'b0;
        if (acc) begin
            if (!id_ok) begin
                do_bad_id = 1'b1;
            end else if (sel_op == OP_LOCK) begin
                if (!is_locked)
                    do_acquire = 1'b1;
                else if (is_owner || is_waiter)
                    do_lock_err = 1'b1;
                else
                    do_enqueue = 1'b1;
            end else begin
                if (!is_locked || !is_owner)
                    do_unlock_err = 1'b1;
                else if (w_none[mid])
                    do_release = 1'b1;
                else
                    do_handoff = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            evt_q     <= '0;
            err_q     <= '0;
            msg_out_q <= '0;
            for (int m = 0; m < NB_MUTEX; m++) begin
                state_q[m]   <= MUTEX_UNLOCKED;
                owner_q[m]   <= '0;
                waiters_q[m] <= '0;
                wptr_q[m]    <= '0;
                msg_q[m]     <= '0;
            end
        end else begin
            evt_q <= '0;
            err_q <= '0;
            if (acc)
                rr_ptr_q <= next_idx(arb_idx);
            unique case (1'b1)
                do_acquire: begin
                    state_q[mid]        <= MUTEX_LOCKED;
                    owner_q[mid]        <= arb_idx;
                    wptr_q[mid]         <= next_idx(arb_idx);
                    evt_q[arb_idx]      <= 1'b1;
                    msg_out_q[arb_idx]  <= msg_q[mid];
                end
                do_enqueue: begin
                    waiters_q[mid][arb_idx] <= 1'b1;
                end
                do_handoff: begin
                    owner_q[mid]           <= w_idx[mid];
                    wptr_q[mid]            <= next_idx(w_idx[mid]);
                    waiters_q[mid]         <= waiters_q[mid] & ~w_onehot[mid];
                    msg_q[mid]             <= sel_wdata;
                    evt_q[w_idx[mid]]      <= 1'b1;
                    msg_out_q[w_idx[mid]]  <= sel_wdata;
                end
                do_release: begin
                    state_q[mid] <= MUTEX_UNLOCKED;
                    msg_q[mid]   <= sel_wdata;
                end
                do_bad_id, do_lock_err, do_unlock_err: begin
                    err_q[arb_idx] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mutex_event_o = evt_q;
    assign err_o         = err_q;
    assign core_msg_o    = msg_out_q;

endmodule

// File: tb/tb_hw_mutex_ctrl.sv
// Directed self-checking bench for hw_mutex_ctrl.
// Three mutexes so that a 2-bit id can name an out-of-range mutex (3).
module tb_hw_mutex_ctrl;
    import event_unit_pkg::*;

    localparam int NC = 4;
    localparam int NM = 3;
    localparam int MW = 32;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [NC-1:0]            core_req_i;
    logic [NC-1:0]            core_op_i;
    logic [NC-1:0][1:0]       core_mutex_id_i;
    logic [NC-1:0][MW-1:0]    core_wdata_i;
    logic [NC-1:0]            core_gnt_o;
    logic [NC-1:0]            mutex_event_o;
    logic [NC-1:0][MW-1:0]    core_msg_o;
    logic [NC-1:0]            err_o;

    int n_checks = 0;
    int n_fail   = 0;

    hw_mutex_ctrl #(
        .NB_CORES    (NC),
        .NB_MUTEX    (NM),
        .MUTEX_MSG_W (MW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .core_req_i      (core_req_i),
        .core_op_i       (core_op_i),
        .core_mutex_id_i (core_mutex_id_i),
        .core_wdata_i    (core_wdata_i),
        .core_gnt_o      (core_gnt_o),
        .mutex_event_o   (mutex_event_o),
        .core_msg_o      (core_msg_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int c, input logic op, input logic [1:0] id,
                         input logic [MW-1:0] wd);
        core_req_i[c]      = 1'b1;
        core_op_i[c]       = op;
        core_mutex_id_i[c] = id;
        core_wdata_i[c]    = wd;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        core_req_i = '0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i           = 1'b1;
        core_req_i      = '1;
        core_op_i       = '1;
        core_mutex_id_i = '0;
        core_wdata_i    = '0;
        step();
        step();
        n_checks++;
        if (core_gnt_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gnt got %b want 0000", core_gnt_o);
        end
        n_checks++;
        if (mutex_event_o !== 4'b0000 || err_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses evt %b err %b want 0", mutex_event_o, err_o);
        end
        n_checks++;
        if (core_msg_o !== '0) begin
            n_fail++;
            $display("FAIL reset_msg got %h want 0", core_msg_o);
        end
        core_req_i = '0;
        rst_i      = 1'b0;
        step();
    endtask

    task automatic test_lock_free();
        drive(2, OP_LOCK, 2'd0, 32'h0);
        #1;
        n_checks++;
        if (core_gnt_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL lock_free_gnt got %b want 0100", core_gnt_o);
        end
        step();
        core_req_i = '0;
        n_checks++;
        if (mutex_event_o !== 4'b0100 || err_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL lock_free_evt evt %b err %b want 0100/0000", mutex_event_o, err_o);
        end
        n_checks++;
        if (core_msg_o[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL lock_free_msg got %h want 0", core_msg_o[2]);
        end
        step();
        n_checks++;
        if (mutex_event_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL lock_free_pulse got %b want 0000", mutex_event_o);
        end
    endtask

    task automatic test_waiters();
        do_reset();
        drive(0, OP_LOCK, 2'd1, 32'h0);
        drive(1, OP_LOCK, 2'd1, 32'h0);
        drive(3, OP_LOCK, 2'd1, 32'h0);
        #1;
        n_checks++;
        if (core_gnt_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL waiters_gnt0 got %b want 0001", core_gnt_o);
        end
        step();
        core_req_i[0] = 1'b0;
        #1;
        n_checks++;
        if (mutex_event_o !== 4'b0001 || core_gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL waiters_c1 evt %b gnt %b want 0001/0010", mutex_event_o, core_gnt_o);
        end
        step();
        core_req_i[1] = 1'b0;
        #1;
        n_checks++;
        if (mutex_event_o !== 4'b0000 || err_o !== 4'b0000 || core_gnt_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL waiters_c2 evt %b err %b gnt %b want 0/0/1000",
                     mutex_event_o, err_o, core_gnt_o);
        end
        step();
        core_req_i[3] = 1'b0;
        n_checks++;
        if (mutex_event_o !== 4'b0000 || err_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL waiters_c3 evt %b err %b want 0/0", mutex_event_o, err_o);
        end
        n_checks++;
        if (dut.waiters_q[1] !== 4'b1010) begin
            n_fail++;
            $display("FAIL waiters_mask got %b want 1010", dut.waiters_q[1]);
        end
    endtask

    task automatic test_handoff();
        drive(0, OP_UNLOCK, 2'd1, 32'hCAFE);
        step();
        core_req_i = '0;
        n_checks++;
        if (mutex_event_o !== 4'b0010 || core_msg_o[1] !== 32'hCAFE) begin
            n_fail++;
            $display("FAIL handoff_1 evt %b msg %h want 0010/cafe", mutex_event_o, core_msg_o[1]);
        end
        drive(1, OP_UNLOCK, 2'd1, 32'hBEEF);
        step();
        core_req_i = '0;
        n_checks++;
        if (mutex_event_o !== 4'b1000 || core_msg_o[3] !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL handoff_3 evt %b msg %h want 1000/beef", mutex_event_o, core_msg_o[3]);
        end
        drive(3, OP_UNLOCK, 2'd1, 32'h1234);
        step();
        core_req_i = '0;
        n_checks++;
        if (mutex_event_o !== 4'b0000 || err_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL handoff_rel evt %b err %b want 0/0", mutex_event_o, err_o);
        end
        n_checks++;
        if (dut.state_q[1] !== MUTEX_UNLOCKED) begin
            n_fail++;
            $display("FAIL handoff_state got %0d want UNLOCKED", dut.state_q[1]);
        end
        n_checks++;
        if (core_msg_o[1] !== 32'hCAFE) begin
            n_fail++;
            $display("FAIL handoff_hold got %h want cafe", core_msg_o[1]);
        end
    endtask

    task automatic test_errors();
        drive(2, OP_LOCK, 2'd0, 32'h0);
        step();
        core_req_i = '0;
        n_checks++;
        if (mutex_event_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL err_setup evt %b want 0100", mutex_event_o);
        end
        drive(1, OP_UNLOCK, 2'd0, 32'h5555);
        step();
        core_req_i = '0;
        n_checks++;
        if (err_o !== 4'b0010 || mutex_event_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL err_nonowner err %b evt %b want 0010/0", err_o, mutex_event_o);
        end
        n_checks++;
        if (dut.owner_q[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL err_owner got %0d want 2", dut.owner_q[0]);
        end
        drive(2, OP_LOCK, 2'd0, 32'h0);
        step();
        core_req_i = '0;
        n_checks++;
        if (err_o !== 4'b0100 || mutex_event_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL err_relock err %b evt %b want 0100/0", err_o, mutex_event_o);
        end
        drive(0, OP_LOCK, 2'd3, 32'h0);
        #1;
        n_checks++;
        if (core_gnt_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL err_badid_gnt got %b want 0001", core_gnt_o);
        end
        step();
        core_req_i = '0;
        n_checks++;
        if (err_o !== 4'b0001 || mutex_event_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL err_badid err %b evt %b want 0001/0", err_o, mutex_event_o);
        end
        drive(0, OP_UNLOCK, 2'd1, 32'h7777);
        step();
        core_req_i = '0;
        n_checks++;
        if (err_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL err_unlocked err %b want 0001", err_o);
        end
        n_checks++;
        if (dut.msg_q[1] !== 32'h1234) begin
            n_fail++;
            $display("FAIL err_msgkept got %h want 1234", dut.msg_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [NC-1:0] exp_g;
        logic [NC-1:0] prev_g;
        do_reset();
        for (int c = 0; c < NC; c++)
            drive(c, OP_LOCK, 2'd3, 32'h0);
        prev_g = '0;
        for (int k = 0; k < 5; k++) begin
            exp_g = NC'(1) << (k % NC);
            #1;
            n_checks++;
            if (core_gnt_o !== exp_g || err_o !== prev_g) begin
                n_fail++;
                $display("FAIL b2b_%0d gnt %b err %b want %b/%b",
                         k, core_gnt_o, err_o, exp_g, prev_g);
            end
            prev_g = exp_g;
            step();
        end
        core_req_i = '0;
        n_checks++;
        if (err_o !== prev_g) begin
            n_fail++;
            $display("FAIL b2b_last err %b want %b", err_o, prev_g);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(0, OP_LOCK, 2'd0, 32'h0);
        step();
        core_req_i = '0;
        drive(1, OP_LOCK, 2'd0, 32'h0);
        drive(2, OP_LOCK, 2'd0, 32'h0);
        step();
        core_req_i[1] = 1'b0;
        step();
        core_req_i = '0;
        n_checks++;
        if (dut.waiters_q[0] !== 4'b0110) begin
            n_fail++;
            $display("FAIL rmid_mask got %b want 0110", dut.waiters_q[0]);
        end
        drive(0, OP_UNLOCK, 2'd0, 32'h9999);
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (core_gnt_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_gnt got %b want 0000", core_gnt_o);
        end
        step();
        n_checks++;
        if (mutex_event_o !== 4'b0000 || err_o !== 4'b0000 || core_msg_o !== '0) begin
            n_fail++;
            $display("FAIL rmid_out evt %b err %b msg %h want 0",
                     mutex_event_o, err_o, core_msg_o);
        end
        rst_i      = 1'b0;
        core_req_i = '0;
        step();
        n_checks++;
        if (mutex_event_o !== 4'b0000 || dut.waiters_q[0] !== 4'b0000 ||
            dut.state_q[0] !== MUTEX_UNLOCKED) begin
            n_fail++;
            $display("FAIL rmid_state evt %b mask %b st %0d want 0/0/UNLOCKED",
                     mutex_event_o, dut.waiters_q[0], dut.state_q[0]);
        end
        drive(3, OP_LOCK, 2'd0, 32'h0);
        #1;
        n_checks++;
        if (core_gnt_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL rmid_gnt3 got %b want 1000", core_gnt_o);
        end
        step();
        core_req_i = '0;
        n_checks++;
        if (mutex_event_o !== 4'b1000 || core_msg_o[3] !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_evt3 evt %b msg %h want 1000/0", mutex_event_o, core_msg_o[3]);
        end
    endtask

    initial begin
        test_reset();
        test_lock_free();
        test_waiters();
        test_handoff();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
